// File: rtl/pipe_ctrl_pkg.sv
// Shared state encodings, pipeline-control bundle and constants for the
// pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W_DEF = 5;
    localparam int ZERO_REG       = 0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } ctrl_state_e;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic idex_we;
        logic exmem_we;
        logic memwb_we;
        logic ifid_flush;
        logic idex_bubble;
        logic memwb_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN = '{pc_we: 1'b1, ifid_we: 1'b1, idex_we: 1'b1,
                                   exmem_we: 1'b1, memwb_we: 1'b1, ifid_flush: 1'b0,
                                   idex_bubble: 1'b0, memwb_bubble: 1'b0};

    // Front of the pipe frozen; WB keeps draining but with a killed write.
    localparam ctrl_t CTRL_FREEZE = '{pc_we: 1'b0, ifid_we: 1'b0, idex_we: 1'b0,
                                      exmem_we: 1'b0, memwb_we: 1'b1, ifid_flush: 1'b0,
                                      idex_bubble: 1'b0, memwb_bubble: 1'b1};

    localparam ctrl_t CTRL_HALT = '{pc_we: 1'b0, ifid_we: 1'b0, idex_we: 1'b0,
                                    exmem_we: 1'b0, memwb_we: 1'b0, ifid_flush: 1'b1,
                                    idex_bubble: 1'b1, memwb_bubble: 1'b1};

    // Normal-running decision: memory stall beats redirect beats load-use.
    function automatic ctrl_t run_ctrl(input logic mem_stall,
                                       input logic redirect,
                                       input logic load_use);
        ctrl_t c;
        c = CTRL_RUN;
        if (mem_stall) begin
            c = CTRL_FREEZE;
        end else if (redirect) begin
            c.ifid_flush  = 1'b1;
            c.idex_bubble = 1'b1;
        end else if (load_use) begin
            c.pc_we       = 1'b0;
            c.ifid_we     = 1'b0;
            c.idex_bubble = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard inputs and per-register control outputs between the datapath and
// the stall/flush sequencer.
interface pipe_stall_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
);

    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rt;
    logic                  idex_MemRead;
    logic [REG_ADDR_W-1:0] idex_DestReg;
    logic                  ex_redirect;
    logic                  exmem_MemAccess;
    logic                  dmem_ack;

    logic                  pc_we;
    logic                  ifid_we;
    logic                  idex_we;
    logic                  exmem_we;
    logic                  memwb_we;
    logic                  ifid_flush;
    logic                  idex_bubble;
    logic                  memwb_bubble;
    logic                  mem_timeout;
    logic [1:0]            ctrl_state;

    // master = the sequencer, slave = the datapath it steers
    modport master (
        input  id_rs, id_rt, id_uses_rt, idex_MemRead, idex_DestReg,
               ex_redirect, exmem_MemAccess, dmem_ack,
        output pc_we, ifid_we, idex_we, exmem_we, memwb_we,
               ifid_flush, idex_bubble, memwb_bubble, mem_timeout, ctrl_state
    );

    modport slave (
        output id_rs, id_rt, id_uses_rt, idex_MemRead, idex_DestReg,
               ex_redirect, exmem_MemAccess, dmem_ack,
        input  pc_we, ifid_we, idex_we, exmem_we, memwb_we,
               ifid_flush, idex_bubble, memwb_bubble, mem_timeout, ctrl_state
    );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination feeds the
// instruction currently in ID.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  idex_MemRead,
    input  logic [REG_ADDR_W-1:0] idex_DestReg,
    output logic                  load_use
);

    // Register zero is hard-wired, so a load into it never creates a hazard.
    assign load_use = idex_MemRead
                   && (idex_DestReg != REG_ADDR_W'(ZERO_REG))
                   && ((idex_DestReg == id_rs)
                       || (id_uses_rt && (idex_DestReg == id_rt)));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (RUN / MEM_WAIT / HALT).
// Optional stall-cycle performance counter under `define PIPE_STALL_PERF_EN.
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    pipe_stall_ctrl_if.master  bus
`ifdef PIPE_STALL_PERF_EN
    ,
    input  logic               perf_clr,
    output logic [31:0]        stall_cycles
`endif
);

    ctrl_state_e      state;
    ctrl_state_e      state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             timeout_q;
    logic             timeout_next;
    logic             load_use;
    logic             mem_stall;
    ctrl_t            ctrl;
    ctrl_t            ctrl_out;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard (
        .id_rs        (bus.id_rs),
        .id_rt        (bus.id_rt),
        .id_uses_rt   (bus.id_uses_rt),
        .idex_MemRead (bus.idex_MemRead),
        .idex_DestReg (bus.idex_DestReg),
        .load_use     (load_use)
    );

    assign mem_stall = bus.exmem_MemAccess && !bus.dmem_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_RUN;
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            timeout_q <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        timeout_next = timeout_q;
        ctrl         = CTRL_HALT;
        case (state)
            ST_RUN: begin
                ctrl     = run_ctrl(mem_stall, bus.ex_redirect, load_use);
                cnt_next = '0;
                if (mem_stall) begin
                    if (MEM_TIMEOUT == 1) begin
                        state_next   = ST_HALT;
                        timeout_next = 1'b1;
                    end else begin
                        state_next = ST_MEM_WAIT;
                        cnt_next   = CNT_W'(1);
                    end
                end
            end
            ST_MEM_WAIT: begin
                // A redirect held through the wait only takes effect on release.
                if (bus.dmem_ack) begin
                    ctrl       = run_ctrl(1'b0, bus.ex_redirect, load_use);
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end else begin
                    ctrl = CTRL_FREEZE;
                    if (cnt == CNT_W'(MEM_TIMEOUT)) begin
                        state_next   = ST_HALT;
                        timeout_next = 1'b1;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            ST_HALT: begin
                ctrl = CTRL_HALT;
            end
            default: begin
                ctrl       = CTRL_HALT;
                state_next = ST_HALT;
            end
        endcase
    end

    // Reset must hold the whole pipe quiet, independent of the state register.
    assign ctrl_out = rst ? ctrl : CTRL_HALT;

    assign bus.pc_we        = ctrl_out.pc_we;
    assign bus.ifid_we      = ctrl_out.ifid_we;
    assign bus.idex_we      = ctrl_out.idex_we;
    assign bus.exmem_we     = ctrl_out.exmem_we;
    assign bus.memwb_we     = ctrl_out.memwb_we;
    assign bus.ifid_flush   = ctrl_out.ifid_flush;
    assign bus.idex_bubble  = ctrl_out.idex_bubble;
    assign bus.memwb_bubble = ctrl_out.memwb_bubble;
    assign bus.mem_timeout  = timeout_q;
    assign bus.ctrl_state   = state;

`ifdef PIPE_STALL_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (perf_clr) begin
            stall_cycles <= '0;
        end else if (!ctrl_out.pc_we && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: one instance with the default timeout
// and one with MEM_TIMEOUT=3 share the same stimulus.
module tb_pipe_stall_ctrl;

    localparam logic [7:0] EXP_RUN    = 8'hF8;
    localparam logic [7:0] EXP_FREEZE = 8'h09;
    localparam logic [7:0] EXP_HALT   = 8'h07;
    localparam logic [7:0] EXP_REDIR  = 8'hFE;
    localparam logic [7:0] EXP_LU     = 8'h3A;
    localparam int         NUM_VECS   = 12;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       mem_read;
        logic [4:0] dest;
        logic       redirect;
        logic       mem_access;
        logic       ack;
    } stim_t;

    typedef struct packed {
        stim_t      stim;
        logic [7:0] exp_ctrl;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       idex_mem_read;
    logic [4:0] idex_dest;
    logic       ex_redirect;
    logic       exmem_access;
    logic       dmem_ack;
    int         check_count = 0;
    int         fail_count  = 0;
    vec_t       vecs [NUM_VECS];

    pipe_stall_ctrl_if #(.REG_ADDR_W(5)) bus0 ();
    pipe_stall_ctrl_if #(.REG_ADDR_W(5)) bus1 ();

    assign bus0.id_rs           = id_rs;
    assign bus0.id_rt           = id_rt;
    assign bus0.id_uses_rt      = id_uses_rt;
    assign bus0.idex_MemRead    = idex_mem_read;
    assign bus0.idex_DestReg    = idex_dest;
    assign bus0.ex_redirect     = ex_redirect;
    assign bus0.exmem_MemAccess = exmem_access;
    assign bus0.dmem_ack        = dmem_ack;
    assign bus1.id_rs           = id_rs;
    assign bus1.id_rt           = id_rt;
    assign bus1.id_uses_rt      = id_uses_rt;
    assign bus1.idex_MemRead    = idex_mem_read;
    assign bus1.idex_DestReg    = idex_dest;
    assign bus1.ex_redirect     = ex_redirect;
    assign bus1.exmem_MemAccess = exmem_access;
    assign bus1.dmem_ack        = dmem_ack;

`ifdef PIPE_STALL_PERF_EN
    logic        perf_clr;
    logic [31:0] stall_cycles0;
    logic [31:0] stall_cycles1;
`endif

    pipe_stall_ctrl #(
        .REG_ADDR_W  (5),
        .MEM_TIMEOUT (15),
        .CNT_W       (8)
    ) dut0 (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus0.master)
`ifdef PIPE_STALL_PERF_EN
        ,
        .perf_clr     (perf_clr),
        .stall_cycles (stall_cycles0)
`endif
    );

    pipe_stall_ctrl #(
        .REG_ADDR_W  (5),
        .MEM_TIMEOUT (3),
        .CNT_W       (8)
    ) dut1 (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus1.master)
`ifdef PIPE_STALL_PERF_EN
        ,
        .perf_clr     (perf_clr),
        .stall_cycles (stall_cycles1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mkStim(input int rs, input int rt, input bit uses_rt,
                                     input bit mem_read, input int dest, input bit redirect,
                                     input bit mem_access, input bit ack);
        stim_t s;
        s.rs         = 5'(rs);
        s.rt         = 5'(rt);
        s.uses_rt    = uses_rt;
        s.mem_read   = mem_read;
        s.dest       = 5'(dest);
        s.redirect   = redirect;
        s.mem_access = mem_access;
        s.ack        = ack;
        return s;
    endfunction

    task automatic applyStimulus(input stim_t s);
        id_rs         = s.rs;
        id_rt         = s.rt;
        id_uses_rt    = s.uses_rt;
        idex_mem_read = s.mem_read;
        idex_dest     = s.dest;
        ex_redirect   = s.redirect;
        exmem_access  = s.mem_access;
        dmem_ack      = s.ack;
    endtask

    task automatic checkOutput(input string name, input int sel, input logic [7:0] exp_ctrl,
                               input logic [1:0] exp_state, input logic exp_to);
        logic [7:0] act_ctrl;
        logic [1:0] act_state;
        logic       act_to;
        if (sel == 0) begin
            act_ctrl  = {bus0.pc_we, bus0.ifid_we, bus0.idex_we, bus0.exmem_we, bus0.memwb_we,
                         bus0.ifid_flush, bus0.idex_bubble, bus0.memwb_bubble};
            act_state = bus0.ctrl_state;
            act_to    = bus0.mem_timeout;
        end else begin
            act_ctrl  = {bus1.pc_we, bus1.ifid_we, bus1.idex_we, bus1.exmem_we, bus1.memwb_we,
                         bus1.ifid_flush, bus1.idex_bubble, bus1.memwb_bubble};
            act_state = bus1.ctrl_state;
            act_to    = bus1.mem_timeout;
        end
        check_count++;
        if (act_ctrl !== exp_ctrl || act_state !== exp_state || act_to !== exp_to) begin
            fail_count++;
            $display("[TB] FAIL %s dut%0d: ctrl=%b state=%0d timeout=%b, expected ctrl=%b state=%0d timeout=%b",
                     name, sel, act_ctrl, act_state, act_to, exp_ctrl, exp_state, exp_to);
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic checkCycle(input string name, input int sel, input logic [7:0] exp_ctrl,
                              input logic [1:0] exp_state, input logic exp_to);
        @(negedge clk);
        checkOutput(name, sel, exp_ctrl, exp_state, exp_to);
        stepClock();
    endtask

    task automatic resetDuts();
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        stepClock();
        rst = 1'b1;
    endtask

`ifdef PIPE_STALL_PERF_EN
    task automatic checkCounter(input string name, input logic [31:0] act, input logic [31:0] exp_val);
        check_count++;
        if (act !== exp_val) begin
            fail_count++;
            $display("[TB] FAIL %s: stall_cycles=%0d, expected %0d", name, act, exp_val);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] r;

        vecs[0]  = '{mkStim(0, 0, 0, 0, 0, 0, 0, 0),   EXP_RUN};
        vecs[1]  = '{mkStim(5, 0, 0, 1, 5, 0, 0, 0),   EXP_LU};
        vecs[2]  = '{mkStim(0, 0, 0, 1, 0, 0, 0, 0),   EXP_RUN};
        vecs[3]  = '{mkStim(3, 7, 1, 1, 7, 0, 0, 0),   EXP_LU};
        vecs[4]  = '{mkStim(3, 7, 0, 1, 7, 0, 0, 0),   EXP_RUN};
        vecs[5]  = '{mkStim(5, 0, 0, 0, 5, 0, 0, 0),   EXP_RUN};
        vecs[6]  = '{mkStim(5, 0, 0, 1, 5, 1, 0, 0),   EXP_REDIR};
        vecs[7]  = '{mkStim(0, 0, 0, 0, 0, 1, 0, 0),   EXP_REDIR};
        vecs[8]  = '{mkStim(0, 0, 0, 0, 0, 0, 1, 1),   EXP_RUN};
        vecs[9]  = '{mkStim(0, 0, 0, 0, 0, 0, 0, 1),   EXP_RUN};
        vecs[10] = '{mkStim(5, 0, 0, 1, 5, 0, 1, 1),   EXP_LU};
        vecs[11] = '{mkStim(30, 31, 1, 1, 31, 0, 0, 0), EXP_LU};

`ifdef PIPE_STALL_PERF_EN
        perf_clr = 1'b0;
`endif
        rst = 1'b1;
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 0));
        #1 rst = 1'b0;

        // Reset held with random inputs: pipe forced quiet.
        for (int i = 0; i < 3; i++) begin
            r = $urandom;
            applyStimulus(r[22:0]);
            @(negedge clk);
            checkOutput("reset_hold", 0, EXP_HALT, 2'd0, 1'b0);
            checkOutput("reset_hold", 1, EXP_HALT, 2'd0, 1'b0);
            stepClock();
        end
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        checkCycle("reset_release", 0, EXP_RUN, 2'd0, 1'b0);

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i].stim);
            checkCycle($sformatf("table_%0d", i), 0, vecs[i].exp_ctrl, 2'd0, 1'b0);
        end

        // Four cycles without ack, then release.
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 1, 0));
        checkCycle("memwait_first", 0, EXP_FREEZE, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) checkCycle("memwait_hold", 0, EXP_FREEZE, 2'd1, 1'b0);
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 1, 1));
        checkCycle("memwait_release", 0, EXP_RUN, 2'd1, 1'b0);
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 0));
        checkCycle("memwait_after", 0, EXP_RUN, 2'd0, 1'b0);

        // Redirect + load-use + memory stall together; redirect lands on release.
        applyStimulus(mkStim(5, 0, 0, 1, 5, 1, 1, 0));
        checkCycle("prio_freeze", 0, EXP_FREEZE, 2'd0, 1'b0);
        checkCycle("prio_wait", 0, EXP_FREEZE, 2'd1, 1'b0);
        applyStimulus(mkStim(5, 0, 0, 1, 5, 1, 1, 1));
        checkCycle("prio_release", 0, EXP_REDIR, 2'd1, 1'b0);
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 0));
        checkCycle("prio_after", 0, EXP_RUN, 2'd0, 1'b0);

        // Asynchronous reset in the middle of a wait.
        resetDuts();
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 1, 0));
        checkCycle("midrst_stall", 0, EXP_FREEZE, 2'd0, 1'b0);
        checkCycle("midrst_wait", 0, EXP_FREEZE, 2'd1, 1'b0);
        #2 rst = 1'b0;
        #1 checkOutput("midrst_async", 0, EXP_HALT, 2'd0, 1'b0);
        stepClock();
        rst = 1'b1;
        checkCycle("midrst_restall", 0, EXP_FREEZE, 2'd0, 1'b0);
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 1, 1));
        checkCycle("midrst_ack", 0, EXP_RUN, 2'd1, 1'b0);

        // MEM_TIMEOUT=3 with no ack ever: HALT, sticky until reset.
        resetDuts();
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 1, 0));
        checkCycle("to_stall", 1, EXP_FREEZE, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) checkCycle("to_wait", 1, EXP_FREEZE, 2'd1, 1'b0);
        checkCycle("to_halt", 1, EXP_HALT, 2'd2, 1'b1);
        applyStimulus(mkStim(5, 0, 0, 1, 5, 1, 1, 1));
        checkCycle("to_held", 1, EXP_HALT, 2'd2, 1'b1);
        resetDuts();
        checkCycle("to_cleared", 1, EXP_RUN, 2'd0, 1'b0);

        // Ack arriving exactly on the timeout cycle wins.
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 1, 0));
        checkCycle("ack3_stall", 1, EXP_FREEZE, 2'd0, 1'b0);
        checkCycle("ack3_wait1", 1, EXP_FREEZE, 2'd1, 1'b0);
        checkCycle("ack3_wait2", 1, EXP_FREEZE, 2'd1, 1'b0);
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 1, 1));
        checkCycle("ack3_release", 1, EXP_RUN, 2'd1, 1'b0);
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 0));
        checkCycle("ack3_run", 1, EXP_RUN, 2'd0, 1'b0);

`ifdef PIPE_STALL_PERF_EN
        resetDuts();
        @(negedge clk);
        checkCounter("perf_reset", stall_cycles0, 32'd0);
        stepClock();
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 4; i++) stepClock();
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 1, 1));
        stepClock();
        applyStimulus(mkStim(5, 0, 0, 1, 5, 0, 0, 0));
        stepClock();
        applyStimulus(mkStim(0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        checkCounter("perf_count", stall_cycles0, 32'd5);
        stepClock();
        perf_clr = 1'b1;
        stepClock();
        perf_clr = 1'b0;
        @(negedge clk);
        checkCounter("perf_clr_dut0", stall_cycles0, 32'd0);
        checkCounter("perf_clr_dut1", stall_cycles1, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
